ifetch_unit: RTL

Instruction fetch stage directly upstream of the mpu core; it drives the core's 32-bit instr input. Owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, and accepts in-order untagged responses. Responses are buffered in a small FIFO and handed downstream with valid/ready. Supports redirect (branch/jump target) with flush of buffered and in-flight instructions.

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads under a credit limit,
// buffers in-order responses in a small FIFO and supports redirect with flush.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  cnt_t          in_flight;
  cnt_t          drop;
  cnt_t          count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic req_fire;
  logic push;
  logic pop;
  logic aligned;
  cnt_t in_flight_next;

  // Credit covers both buffered words and outstanding reads, so the FIFO can never overflow.
  always_comb begin
    imem_req_valid = !reset && !fault && !redirect_valid &&
                     ((sum_t'(in_flight) + sum_t'(count)) < sum_t'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    instr_valid    = (count != '0);
    instr          = instr_valid ? data_mem[rd_ptr] : '0;
    instr_pc       = instr_valid ? pc_mem[rd_ptr] : '0;
    pop            = instr_valid && instr_ready;
    push           = imem_rsp_valid && (drop == '0) && !redirect_valid && !fault;
    aligned        = (redirect_pc[1:0] == 2'b00);
    in_flight_next = in_flight + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop      <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fault     <= 1'b0;
    end else begin
      in_flight <= in_flight_next;
      if (redirect_valid) begin
        // Everything still owed by memory belongs to the old path and is discarded on arrival.
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        drop   <= in_flight_next;
        if (aligned) begin
          fetch_pc <= redirect_pc;
          rsp_pc   <= redirect_pc;
        end else begin
          fault <= 1'b1;
        end
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - cnt_t'(1);
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      data_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  always @(posedge clock) begin
    if (!reset && imem_rsp_valid)
      assert (in_flight != '0) else $error("ifetch_unit: response with no request in flight");
  end

endmodule
